// File: rtl/digit_serial_addsub_if.sv
// Start/done bus for digit_serial_addsub.
// Optional macro ADDSUB_ZERO_FLAG_EN adds the registered Zero result flag.
//
// Handshake: a request is the pair (start, sub/A/B/Cin) seen at a rising
// clock edge while busy=0. The slave captures the operands on that edge and
// the master may change them freely afterwards. Requests seen while busy=1
// are dropped. done is a single-cycle pulse; Sum/Cout/Overflow(/Zero) are
// valid from that cycle and hold until the next operation completes.
interface digit_serial_addsub_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Overflow;
`ifdef ADDSUB_ZERO_FLAG_EN
  logic             Zero;
`endif

  // Requester side: drives operands, observes status and results.
  modport master (
    output start, sub, A, B, Cin,
`ifdef ADDSUB_ZERO_FLAG_EN
    input  Zero,
`endif
    input  busy, done, Sum, Cout, Overflow
  );

  // Unit side: consumes operands, produces status and results.
  modport slave (
    input  start, sub, A, B, Cin,
`ifdef ADDSUB_ZERO_FLAG_EN
    output Zero,
`endif
    output busy, done, Sum, Cout, Overflow
  );
endinterface

// File: rtl/digit_serial_addsub.sv
// Digit-serial two's-complement adder/subtractor.
// Processes DIGIT bits per clock through one DIGIT-wide ripple slice with
// the carry held in a register between digits; WIDTH/DIGIT RUN cycles per
// operation. Optional macro ADDSUB_ZERO_FLAG_EN adds the Zero result flag.
// WIDTH must be >= 2 and DIGIT must divide WIDTH exactly.
module digit_serial_addsub #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic                  clock,
  input  logic                  clear,
  digit_serial_addsub_if.slave  bus,
  output logic [1:0]            fsm_state
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);
  localparam int MSB  = WIDTH - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_n;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_n;
  logic [DIGIT-1:0] slice_a;
  logic [DIGIT-1:0] slice_b;
  logic [DIGIT-1:0] slice_sum;
  logic             slice_cout;
  logic             accept;
  logic             last;

  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
`ifdef ADDSUB_ZERO_FLAG_EN
  logic             zero_r;
`endif

  // A new request is taken in IDLE and also in DONE, so back-to-back issue
  // costs no bubble cycle.
  assign accept = bus.start && ((state == S_IDLE) || (state == S_DONE));
  assign last   = (state == S_RUN) && (k == K_LAST);

  // Ripple slice for digit k, plus the result word with that digit merged in.
  always_comb begin
    int idx;
    idx        = int'(k) * DIGIT;
    slice_a    = op_a[idx +: DIGIT];
    slice_b    = op_b[idx +: DIGIT];
    {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b}
                            + {{DIGIT{1'b0}}, carry};
    res_n      = res;
    res_n[idx +: DIGIT] = slice_sum;
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept) state_n = S_RUN;
      S_RUN:   if (last)   state_n = S_DONE;
      S_DONE:  state_n = accept ? S_RUN : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Control state, digit counter and registered status flags.
  always_ff @(posedge clock) begin
    if (clear) begin
      state  <= S_IDLE;
      k      <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      busy_r <= (state_n == S_RUN);
      done_r <= (state_n == S_DONE);
      if (accept) begin
        k <= '0;
      end else if (state == S_RUN) begin
        k <= last ? '0 : k + 1'b1;
      end
    end
  end

  // Operand capture and per-digit datapath. Subtraction is A + ~B + 1, so
  // the inversion and the forced carry-in are applied once at capture.
  always_ff @(posedge clock) begin
    if (clear) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      res   <= '0;
    end else if (accept) begin
      op_a  <= bus.A;
      op_b  <= bus.sub ? ~bus.B : bus.B;
      carry <= bus.sub ? 1'b1 : bus.Cin;
    end else if (state == S_RUN) begin
      res   <= res_n;
      carry <= slice_cout;
    end
  end

  // Visible results change together, only on the final digit edge, and then
  // hold until the next operation finishes. Overflow compares operand signs
  // against the result sign, using the already-inverted B for subtraction.
  always_ff @(posedge clock) begin
    if (clear) begin
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
`ifdef ADDSUB_ZERO_FLAG_EN
      zero_r <= 1'b0;
`endif
    end else if (last) begin
      sum_r  <= res_n;
      cout_r <= slice_cout;
      ovf_r  <= (op_a[MSB] == op_b[MSB]) && (res_n[MSB] != op_a[MSB]);
`ifdef ADDSUB_ZERO_FLAG_EN
      zero_r <= (res_n == '0);
`endif
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.Sum      = sum_r;
  assign bus.Cout     = cout_r;
  assign bus.Overflow = ovf_r;
`ifdef ADDSUB_ZERO_FLAG_EN
  assign bus.Zero     = zero_r;
`endif
  assign fsm_state    = state;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Self-checking bench for digit_serial_addsub: 32/8 main instance plus
// 16/4 and 8/8 instances for the parameter sweep.
module tb_digit_serial_addsub;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic clear = 1'b1;
  always #5 clock = ~clock;

  digit_serial_addsub_if #(.WIDTH(32)) bus32 ();
  digit_serial_addsub_if #(.WIDTH(16)) bus16 ();
  digit_serial_addsub_if #(.WIDTH(8))  bus8  ();
  logic [1:0] st32, st16, st8;

  digit_serial_addsub #(.WIDTH(32), .DIGIT(8)) dut32 (
    .clock(clock), .clear(clear), .bus(bus32), .fsm_state(st32));
  digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clock(clock), .clear(clear), .bus(bus16), .fsm_state(st16));
  digit_serial_addsub #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clock(clock), .clear(clear), .bus(bus8), .fsm_state(st8));

  int n_assert = 0;
  int n_fail   = 0;
  int lat_g;
  int busy_g;
  logic [33:0] exp_q[$];   // {overflow, cout, sum[31:0]}

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Unsigned and signed interpretation with plain integer arithmetic.
  function automatic logic [33:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin,
                                        input logic s);
    longint lim, ua, ub, r, sa, sb, sr;
    logic c, ov;
    lim = longint'(1) << w;
    ua  = longint'(a) % lim;
    ub  = longint'(b) % lim;
    sa  = (ua >= lim / 2) ? ua - lim : ua;
    sb  = (ub >= lim / 2) ? ub - lim : ub;
    if (!s) begin
      r  = ua + ub + longint'(cin);
      c  = (r >= lim);
      sr = sa + sb + longint'(cin);
    end else begin
      r  = ua - ub + lim;
      c  = (ua >= ub);
      sr = sa - sb;
    end
    ov = (sr >= lim / 2) || (sr < -(lim / 2));
    return {ov, c, 32'(r % lim)};
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers for the 32-bit instance ----------------
  task automatic tick32();
    @(posedge clock); #1;
    lat_g++;
    if (bus32.busy) busy_g++;
  endtask

  // Present a request for one edge, then scramble the inputs.
  task automatic launch32(input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic s, input logic [33:0] e);
    @(negedge clock);
    bus32.start = 1'b1; bus32.A = a; bus32.B = b; bus32.Cin = cin; bus32.sub = s;
    exp_q.push_back(e);
    @(posedge clock); #1;
    bus32.start = 1'b0;
    bus32.A = $urandom; bus32.B = $urandom;
    bus32.Cin = 1'($urandom_range(0, 1)); bus32.sub = 1'($urandom_range(0, 1));
    lat_g  = 0;
    busy_g = bus32.busy ? 1 : 0;
  endtask

  task automatic finish32(input string tag);
    logic [33:0] e;
    while (!bus32.done && lat_g < 40) tick32();
    check({tag, "_done"}, 64'(bus32.done), 64'd1);
    check({tag, "_lat"}, 64'(lat_g), 64'd4);
    check({tag, "_busy"}, 64'(busy_g), 64'd4);
    e = exp_q.pop_front();
    check({tag, "_sum"}, 64'(bus32.Sum), 64'(e[31:0]));
    check({tag, "_cout"}, 64'(bus32.Cout), 64'(e[32]));
    check({tag, "_ovf"}, 64'(bus32.Overflow), 64'(e[33]));
`ifdef ADDSUB_ZERO_FLAG_EN
    check({tag, "_zero"}, 64'(bus32.Zero), 64'(e[31:0] == 32'd0));
`endif
  endtask

  // ---------------- drivers for the sweep instances ----------------
  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic s);
    logic [33:0] e;
    int lat;
    e = model(16, 32'(a), 32'(b), cin, s);
    @(negedge clock);
    bus16.start = 1'b1; bus16.A = a; bus16.B = b; bus16.Cin = cin; bus16.sub = s;
    @(posedge clock); #1;
    bus16.start = 1'b0; bus16.A = 16'($urandom); bus16.B = 16'($urandom);
    lat = 0;
    while (!bus16.done && lat < 40) begin @(posedge clock); #1; lat++; end
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check({tag, "_sum"}, 64'(bus16.Sum), 64'(e[15:0]));
    check({tag, "_cout"}, 64'(bus16.Cout), 64'(e[32]));
    check({tag, "_ovf"}, 64'(bus16.Overflow), 64'(e[33]));
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic cin, input logic s);
    logic [33:0] e;
    int lat;
    e = model(8, 32'(a), 32'(b), cin, s);
    @(negedge clock);
    bus8.start = 1'b1; bus8.A = a; bus8.B = b; bus8.Cin = cin; bus8.sub = s;
    @(posedge clock); #1;
    bus8.start = 1'b0; bus8.A = 8'($urandom); bus8.B = 8'($urandom);
    lat = 0;
    while (!bus8.done && lat < 40) begin @(posedge clock); #1; lat++; end
    check({tag, "_lat"}, 64'(lat), 64'd1);
    check({tag, "_sum"}, 64'(bus8.Sum), 64'(e[7:0]));
    check({tag, "_cout"}, 64'(bus8.Cout), 64'(e[32]));
    check({tag, "_ovf"}, 64'(bus8.Overflow), 64'(e[33]));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] ra, rb, held;
    logic rc, rs;
    int seen;

    bus32.start = 0; bus32.sub = 0; bus32.A = 0; bus32.B = 0; bus32.Cin = 0;
    bus16.start = 0; bus16.sub = 0; bus16.A = 0; bus16.B = 0; bus16.Cin = 0;
    bus8.start  = 0; bus8.sub  = 0; bus8.A  = 0; bus8.B  = 0; bus8.Cin  = 0;

    // Reset state
    clear = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 64'(bus32.busy), 64'd0);
    check("rst_done", 64'(bus32.done), 64'd0);
    check("rst_sum", 64'(bus32.Sum), 64'd0);
    check("rst_cout", 64'(bus32.Cout), 64'd0);
    check("rst_ovf", 64'(bus32.Overflow), 64'd0);
    check("rst16_sum", 64'(bus16.Sum), 64'd0);
    check("rst8_done", 64'(bus8.done), 64'd0);
    @(negedge clock);
    clear = 1'b0;

    // Add with carry-in, then result hold after the done pulse
    launch32(32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0, {1'b0, 1'b0, 32'h0000_0101});
    finish32("add_cin");
    tick32();
    check("hold_done", 64'(bus32.done), 64'd0);
    check("hold_sum", 64'(bus32.Sum), 64'h0000_0101);

    // Full carry ripple
    launch32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0});
    finish32("ripple");

    // Subtract with signed overflow; Cin is ignored
    launch32(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF});
    finish32("sub_ovf");

    // Clear during the 2nd RUN cycle discards the operation
    launch32(32'h1234_5678, 32'h0101_0101, 1'b0, 1'b0, 34'd0);
    void'(exp_q.pop_back());
    tick32();
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock); #1;
    check("clr_busy", 64'(bus32.busy), 64'd0);
    check("clr_done", 64'(bus32.done), 64'd0);
    check("clr_sum", 64'(bus32.Sum), 64'd0);
    check("clr_cout", 64'(bus32.Cout), 64'd0);
    check("clr_ovf", 64'(bus32.Overflow), 64'd0);
    @(negedge clock);
    clear = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clock); #1;
      if (bus32.done) seen++;
    end
    check("clr_no_done", 64'(seen), 64'd0);

    // Fresh start after clear: 5 - 7
    launch32(32'd5, 32'd7, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
    finish32("sub_neg");

    // Start pulsed while busy is ignored
    launch32(32'h0000_1000, 32'h0000_0234, 1'b0, 1'b0, {1'b0, 1'b0, 32'h0000_1234});
    tick32();
    @(negedge clock);
    bus32.start = 1'b1; bus32.A = 32'hDEAD_BEEF; bus32.B = 32'h1111_1111; bus32.sub = 1'b1;
    tick32();
    bus32.start = 1'b0;
    finish32("busy_ign");
    held = bus32.Sum;
    repeat (6) tick32();
    check("busy_ign_hold", 64'(bus32.Sum), 64'(held));

    // Back-to-back: start presented in the done cycle
    launch32(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 1'b0, {1'b0, 1'b0, 32'h1010_1011});
    finish32("b2b_first");
    launch32(32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1, {1'b1, 1'b0, 32'h8000_0000});
    finish32("b2b_second");

    // Random operations, every other one issued back-to-back
    for (int i = 0; i < 16; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 4 == 0) rb = ra;
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      launch32(ra, rb, rc, rs, model(32, ra, rb, rc, rs));
      finish32($sformatf("rnd%0d", i));
      if (i % 2 == 1) tick32();
    end

    // Parameter sweep
    op16("w16_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      op16($sformatf("w16_rnd%0d", i), 16'($urandom), 16'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    op8("w8_ovf", 8'h7F, 8'h01, 1'b0, 1'b0);
    op8("w8_sub", 8'h03, 8'h05, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      op8($sformatf("w8_rnd%0d", i), 8'($urandom), 8'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
